// File: rtl/cache_pkg.sv
// Shared types, constants and helpers for the set-associative cache.
// Line geometry is fixed at 32-byte lines; word select is addr[4:2].
package cache_pkg;

    localparam int LINE_W       = 256;
    localparam int OFFSET_W     = 5;
    localparam int WORD_SEL_LSB = 2;
    localparam int WORD_W       = 32;
    localparam int WSEL_W       = OFFSET_W - WORD_SEL_LSB;

    typedef enum logic [2:0] {
        IDLE,
        TAG_CHECK,
        WRITEBACK,
        ALLOCATE,
        FILL_WAIT
    } cache_state_t;

    // Byte-merge a store into one 32-bit word of a line.
    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [WSEL_W-1:0] word_idx,
        input logic [WORD_W-1:0] wdata,
        input logic [3:0]        wmask
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
                res[WORD_W*int'(word_idx) + 8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/param_wb_cache_plru_tree.sv
// Tree pseudo-LRU for one set: victim selection and update on access.
// Node bit 0 means the victim lies in the lower-way subtree.
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         state_i,
    input  logic [$clog2(WAYS)-1:0] access_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    output logic [WAYS-2:0]         next_o
);

    localparam int WAY_W = $clog2(WAYS);

    logic [WAYS-1:0] vmatch;

    // A way is the victim when every node on its path points toward it.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [WAY_W-1:0] ok;
        for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
            localparam int NODE = (2**l - 1) + (w >> (WAY_W - l));
            localparam bit DIR  = ((w >> (WAY_W - 1 - l)) & 1) != 0;
            assign ok[l] = (state_i[NODE] == DIR);
        end
        assign vmatch[w] = &ok;
    end

    // Exactly one way matches; encode it.
    for (genvar b = 0; b < WAY_W; b++) begin : g_venc
        logic [WAYS-1:0] sel;
        for (genvar w = 0; w < WAYS; w++) begin : g_w
            assign sel[w] = vmatch[w] & (((w >> b) & 1) != 0);
        end
        assign victim_o[b] = |sel;
    end

    // Nodes on the accessed path flip to point away from the accessed way.
    for (genvar j = 0; j < WAYS-1; j++) begin : g_node
        localparam int L   = $clog2(j + 2) - 1;
        localparam int POS = j - (2**L - 1);
        logic on_path;
        assign on_path   = ((access_i >> (WAY_W - L)) == WAY_W'(POS));
        assign next_o[j] = on_path ? ~access_i[WAY_W-1-L] : state_i[j];
    end

endmodule

// File: rtl/param_wb_cache.sv
// N-way set-associative write-back, write-allocate cache with tree-PLRU.
// Optional macro CACHE_PERF_CNT_EN adds hit/miss counter ports.
module param_wb_cache
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ufp_addr,
    input  logic [3:0]        ufp_rmask,
    input  logic [3:0]        ufp_wmask,
    input  logic [31:0]       ufp_wdata,
    output logic [LINE_W-1:0] ufp_rdata,
    output logic              ufp_resp,
    output logic [31:0]       dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [LINE_W-1:0] dfp_wdata,
    input  logic [LINE_W-1:0] dfp_rdata,
    input  logic              dfp_resp
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - OFFSET_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [LINE_W-1:0] line_t;

    cache_state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic        is_wr_q;

    tag_t            tag_q   [SETS][WAYS];
    line_t           data_q  [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];

    tag_t            rd_tag_q  [WAYS];
    line_t           rd_data_q [WAYS];
    logic [WAYS-1:0] rd_valid_q;
    logic [WAYS-1:0] rd_dirty_q;
    logic [WAYS-2:0] rd_plru_q;

    logic             req;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] cur_idx;
    tag_t             cur_tag;
    logic [WSEL_W-1:0] word_sel;

    logic [WAYS-1:0]  hit_vec, inv_vec;
    logic [WAYS-1:0]  hit_oh, inv_oh;
    logic [WAY_W-1:0] hit_way, inv_way;
    logic             hit, has_inv;
    logic [WAY_W-1:0] plru_victim, miss_victim;
    logic [WAYS-2:0]  plru_next;
    logic [WAY_W-1:0] victim_q;

    logic hit_upd, fill_en, victim_ld;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{ufp_addr[1:0], addr_q[1:0], addr_q[OFFSET_W-1:WSEL_W+WORD_SEL_LSB+0]};

    assign req      = (|ufp_rmask) || (|ufp_wmask);
    assign cur_idx  = addr_q[OFFSET_W +: IDX_W];
    assign cur_tag  = addr_q[31 -: TAG_W];
    assign word_sel = addr_q[WORD_SEL_LSB +: WSEL_W];
    assign rd_idx   = (state_q == IDLE) ? ufp_addr[OFFSET_W +: IDX_W] : cur_idx;

    // Per-way hit and invalid flags from the registered array read.
    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_vec[w] = rd_valid_q[w] && (rd_tag_q[w] == cur_tag);
        assign inv_vec[w] = ~rd_valid_q[w];
    end

    assign hit_oh  = hit_vec & (~hit_vec + WAYS'(1));
    assign inv_oh  = inv_vec & (~inv_vec + WAYS'(1));
    assign hit     = |hit_vec;
    assign has_inv = |inv_vec;

    // Encode the lowest-numbered hit and invalid ways.
    for (genvar b = 0; b < WAY_W; b++) begin : g_enc
        logic [WAYS-1:0] hsel, isel;
        for (genvar w = 0; w < WAYS; w++) begin : g_w
            assign hsel[w] = hit_oh[w] & (((w >> b) & 1) != 0);
            assign isel[w] = inv_oh[w] & (((w >> b) & 1) != 0);
        end
        assign hit_way[b] = |hsel;
        assign inv_way[b] = |isel;
    end

    plru_tree #(
        .WAYS(WAYS)
    ) u_plru (
        .state_i (rd_plru_q),
        .access_i(hit_way),
        .victim_o(plru_victim),
        .next_o  (plru_next)
    );

    assign miss_victim = has_inv ? inv_way : plru_victim;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state, handshake outputs and array write strobes.
    always_comb begin
        state_d   = state_q;
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        hit_upd   = 1'b0;
        fill_en   = 1'b0;
        victim_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = TAG_CHECK;
            end
            TAG_CHECK: begin
                if (hit) begin
                    ufp_resp  = 1'b1;
                    ufp_rdata = rd_data_q[hit_way];
                    hit_upd   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    victim_ld = 1'b1;
                    if (rd_valid_q[miss_victim] && rd_dirty_q[miss_victim])
                        state_d = WRITEBACK;
                    else
                        state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                dfp_addr  = {rd_tag_q[victim_q], cur_idx, OFFSET_W'(0)};
                dfp_wdata = rd_data_q[victim_q];
                if (dfp_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                dfp_read = 1'b1;
                dfp_addr = {addr_q[31:OFFSET_W], OFFSET_W'(0)};
                if (dfp_resp) begin
                    fill_en = 1'b1;
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                state_d = TAG_CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the request on acceptance in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
        end else if (state_q == IDLE && req) begin
            addr_q  <= ufp_addr;
            wmask_q <= ufp_wmask;
            wdata_q <= ufp_wdata;
            is_wr_q <= |ufp_wmask;
        end
    end

    // Miss victim is held across writeback and fill.
    always_ff @(posedge clk) begin
        if (!rst)           victim_q <= '0;
        else if (victim_ld) victim_q <= miss_victim;
    end

    // Valid, dirty and PLRU state with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            if (hit_upd) begin
                plru_q[cur_idx] <= plru_next;
                if (is_wr_q) dirty_q[cur_idx][hit_way] <= 1'b1;
            end
            if (fill_en) begin
                valid_q[cur_idx][victim_q] <= 1'b1;
                dirty_q[cur_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and data storage: store merge on write hit, line on fill.
    always_ff @(posedge clk) begin
        if (rst && hit_upd && is_wr_q) begin
            data_q[cur_idx][hit_way] <=
                merge_word(rd_data_q[hit_way], word_sel, wdata_q, wmask_q);
        end
        if (rst && fill_en) begin
            data_q[cur_idx][victim_q] <= dfp_rdata;
            tag_q[cur_idx][victim_q]  <= cur_tag;
        end
    end

    // One-cycle synchronous read of the indexed set.
    always_ff @(posedge clk) begin
        rd_tag_q   <= tag_q[rd_idx];
        rd_data_q  <= data_q[rd_idx];
        rd_valid_q <= valid_q[rd_idx];
        rd_dirty_q <= dirty_q[rd_idx];
        rd_plru_q  <= plru_q[rd_idx];
    end

`ifdef CACHE_PERF_CNT_EN
    logic        from_fill_q;
    logic [31:0] hits_q, misses_q;

    // Count first-look hits and misses; fill re-checks are not hits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            from_fill_q <= 1'b0;
            hits_q      <= '0;
            misses_q    <= '0;
        end else begin
            from_fill_q <= (state_q == FILL_WAIT);
            if (state_q == TAG_CHECK && hit && !from_fill_q)
                hits_q <= hits_q + 32'd1;
            if (state_q == TAG_CHECK && !hit)
                misses_q <= misses_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_param_wb_cache.sv
// Directed vector bench for param_wb_cache with a simple line memory model.
// Memory default line at address la holds word w = la + w.
module tb_param_wb_cache;
    import cache_pkg::*;

    logic              clk;
    logic              rst;
    logic [31:0]       ufp_addr;
    logic [3:0]        ufp_rmask;
    logic [3:0]        ufp_wmask;
    logic [31:0]       ufp_wdata;
    logic [LINE_W-1:0] ufp_rdata;
    logic              ufp_resp;
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;
`endif

    param_wb_cache #(.WAYS(4), .SETS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ufp_addr (ufp_addr),
        .ufp_rmask(ufp_rmask),
        .ufp_wmask(ufp_wmask),
        .ufp_wdata(ufp_wdata),
        .ufp_rdata(ufp_rdata),
        .ufp_resp (ufp_resp),
        .dfp_addr (dfp_addr),
        .dfp_read (dfp_read),
        .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata),
        .dfp_rdata(dfp_rdata),
        .dfp_resp (dfp_resp)
`ifdef CACHE_PERF_CNT_EN
        ,
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_b;
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic        miss;
        logic        wb;
        logic [31:0] wba;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[20];

    int total = 0;
    int bad   = 0;

    logic [LINE_W-1:0] mem [logic [31:0]];

    int                got, nrd, nwr, wb_k, rd_k, rresp_k, resp_k;
    logic [31:0]       rd_addr, wb_addr;
    logic [LINE_W-1:0] wb_data, rdata;

    function automatic logic [LINE_W-1:0] defline(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = la + 32'(w);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] memline(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return defline(la);
    endfunction

    task automatic chk(input string nm, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issue one request and service the memory side with one wait cycle.
    task automatic do_req(input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
        int seen;
        got = 0; nrd = 0; nwr = 0; seen = 0;
        wb_k = -1; rd_k = -1; rresp_k = -1; resp_k = -1;
        rd_addr = '0; wb_addr = '0; wb_data = '0; rdata = '0;
        @(negedge clk);
        ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk);
            dfp_resp = 1'b0;
            if (ufp_resp) begin
                got = 1; resp_k = k; rdata = ufp_rdata;
                ufp_rmask = '0; ufp_wmask = '0;
            end else if (dfp_write || dfp_read) begin
                seen++;
                if (seen == 2) begin
                    seen = 0;
                    dfp_resp = 1'b1;
                    if (dfp_write) begin
                        nwr++; wb_k = k; wb_addr = dfp_addr; wb_data = dfp_wdata;
                        mem[dfp_addr] = dfp_wdata;
                    end else begin
                        nrd++; rd_k = k; rresp_k = k; rd_addr = dfp_addr;
                        dfp_rdata = memline(dfp_addr);
                    end
                end
            end
        end
        dfp_resp = 1'b0;
        ufp_rmask = '0; ufp_wmask = '0;
    endtask

    function automatic string nm(input int i, input string s);
        return $sformatf("v%0d_%s", i, s);
    endfunction

    logic [LINE_W-1:0] L;
    int                seen_rd;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]       ph1, pm1;
`endif

    initial begin
        rst = 1'b0; ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0;
        ufp_wdata = '0; dfp_rdata = '0; dfp_resp = 1'b0;

        vecs[0]  = '{0, 32'h1044, 4'h0, 4'h2, 32'hAABBCCDD, 0, 0, 32'h0, 32'h0};
        vecs[1]  = '{0, 32'h1044, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h1122CC44};
        vecs[2]  = '{0, 32'h1048, 4'hF, 4'h1, 32'h000000EE, 0, 0, 32'h0, 32'h0};
        vecs[3]  = '{0, 32'h1048, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h000010EE};
        vecs[4]  = '{0, 32'h2040, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h2040};
        vecs[5]  = '{0, 32'h3044, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h3041};
        vecs[6]  = '{0, 32'h5040, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h5040};
        vecs[7]  = '{0, 32'h7050, 4'hF, 4'h0, 32'h0, 1, 1, 32'h1040, 32'h7044};
        vecs[8]  = '{0, 32'h1044, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h1122CC44};
        vecs[9]  = '{0, 32'h1048, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h000010EE};
        vecs[10] = '{1, 32'h0240, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0240};
        vecs[11] = '{0, 32'h0440, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0440};
        vecs[12] = '{0, 32'h0640, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0640};
        vecs[13] = '{0, 32'h0840, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0840};
        vecs[14] = '{0, 32'h0240, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0240};
        vecs[15] = '{0, 32'h0A40, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0A40};
        vecs[16] = '{0, 32'h0240, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0240};
        vecs[17] = '{0, 32'h0440, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0440};
        vecs[18] = '{0, 32'h0840, 4'hF, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0840};
        vecs[19] = '{0, 32'h0640, 4'hF, 4'h0, 32'h0, 1, 0, 32'h0, 32'h0640};

        L = defline(32'h1040);
        L[63:32] = 32'h11223344;
        mem[32'h1040] = L;

        repeat (2) @(negedge clk);
        chk("rst_resp", ufp_resp, 0);
        chk("rst_dread", dfp_read, 0);
        chk("rst_dwrite", dfp_write, 0);
        chk("rst_rdata", ufp_rdata, 0);
        chk("rst_daddr", dfp_addr, 0);
`ifdef CACHE_PERF_CNT_EN
        chk("rst_phits", perf_hits, 0);
        chk("rst_pmiss", perf_misses, 0);
`endif
        rst = 1'b1;

        // Cold read miss, then hit.
        do_req(32'h1044, 4'hF, 4'h0, 32'h0);
        chk("s1_resp", got, 1);
        chk("s1_nrd", nrd, 1);
        chk("s1_nwr", nwr, 0);
        chk("s1_daddr", rd_addr, 32'h1040);
        chk("s1_line", rdata, L);
        chk("s1_lat", resp_k, rresp_k + 2);
        do_req(32'h1044, 4'hF, 4'h0, 32'h0);
        chk("s1h_resp", got, 1);
        chk("s1h_lat", resp_k, 1);
        chk("s1h_dfp", nrd + nwr, 0);
        chk("s1h_line", rdata, L);
`ifdef CACHE_PERF_CNT_EN
        ph1 = perf_hits; pm1 = perf_misses;
        chk("s1_phits", ph1, 1);
        chk("s1_pmiss", pm1, 1);
`endif

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst_b) begin
                @(negedge clk); rst = 1'b0;
                @(negedge clk); rst = 1'b1;
            end
            do_req(vecs[i].addr, vecs[i].rm, vecs[i].wm, vecs[i].wd);
            chk(nm(i, "resp"), got, 1);
            chk(nm(i, "miss"), nrd, 32'(vecs[i].miss));
            chk(nm(i, "wb"), nwr, 32'(vecs[i].wb));
            if (vecs[i].wb) begin
                chk(nm(i, "wbaddr"), wb_addr, vecs[i].wba);
                chk(nm(i, "wbfirst"), wb_k < rd_k, 1);
            end
            if (vecs[i].miss) begin
                chk(nm(i, "daddr"), rd_addr, {vecs[i].addr[31:5], 5'b0});
                chk(nm(i, "lat"), resp_k, rresp_k + 2);
            end else begin
                chk(nm(i, "lat"), resp_k, 1);
            end
            if (vecs[i].wm == 4'h0) begin
                chk(nm(i, "word"), rdata[32*int'(vecs[i].addr[4:2]) +: 32],
                    vecs[i].word);
            end
`ifdef CACHE_PERF_CNT_EN
            if (i == 18) begin
                chk("perf_misses", pm1 + perf_misses, 6);
                chk("perf_hits", ph1 + perf_hits, 5);
            end
`endif
        end

        // Stray memory response while idle has no effect.
        @(negedge clk); dfp_resp = 1'b1;
        @(negedge clk); dfp_resp = 1'b0;
        chk("stray_resp", ufp_resp, 0);
        chk("stray_state", dut.state_q, IDLE);
        do_req(32'h0840, 4'hF, 4'h0, 32'h0);
        chk("stray_hit_lat", resp_k, 1);
        chk("stray_hit_word", rdata[31:0], 32'h0840);

        // Reset while the fill is outstanding.
        @(negedge clk);
        ufp_addr = 32'h0C40; ufp_rmask = 4'hF; ufp_wmask = '0;
        seen_rd = 0;
        for (int k = 0; k < 20 && seen_rd == 0; k++) begin
            @(negedge clk);
            if (dfp_read) seen_rd = 1;
        end
        chk("s5_alloc", seen_rd, 1);
        chk("s5_daddr", dfp_addr, 32'h0C40);
        rst = 1'b0; ufp_rmask = '0;
        @(negedge clk);
        rst = 1'b1;
        chk("s5_dread", dfp_read, 0);
        chk("s5_dwrite", dfp_write, 0);
        chk("s5_resp", ufp_resp, 0);
        chk("s5_state", dut.state_q, IDLE);
        do_req(32'h0440, 4'hF, 4'h0, 32'h0);
        chk("s5_resp2", got, 1);
        chk("s5_miss", nrd, 1);
        chk("s5_word", rdata[31:0], 32'h0440);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
